// File: rtl/mult_seq_16b_if.sv
// mult_seq_16b_if: operand/result bundle for the sequential multiplier
interface mult_seq_16b_if #(parameter int N = 16);
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;
  modport master(output start, A, B, input P, busy, done);
  modport slave(input start, A, B, output P, busy, done);
endinterface

// File: rtl/mult_seq_16b.sv
// mult_seq_16b: radix-2 shift-add unsigned multiplier, one product bit per cycle
module mult_seq_16b #(parameter int N = 16) (
  input logic           clk,
  input logic           rst,
  mult_seq_16b_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  m_q, m_d, acc_q, acc_d, q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    sum;
  logic          load, run;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (bus.start ? RUN : IDLE) :
              (state_q == RUN)  ? ((cnt_q == CW'(N - 1)) ? DONE : RUN) : IDLE;
  end
  // carry-out lands in ACC[N-1] by taking the top N bits of the N+1-bit sum
  always_comb begin
    load  = (state_q == IDLE) && bus.start;
    run   = (state_q == RUN);
    sum   = {1'b0, acc_q} + {1'b0, q_q[0] ? m_q : {N{1'b0}}};
    m_d   = load ? bus.A : m_q;
    acc_d = load ? '0 : run ? sum[N:1] : acc_q;
    q_d   = load ? bus.B : run ? {sum[0], q_q[N-1:1]} : q_q;
    cnt_d = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
  end
  always_comb begin
    bus.P    = {acc_q, q_q};
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end
endmodule

// File: doc/mult_seq_16b.md
MULT_SEQ_16B -- requirements
Module: mult_seq_16b

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on the rising edge of clk.
REQ-005 The block SHALL have port A, input, N bits: unsigned multiplicand, sampled only when start is accepted.
REQ-006 The block SHALL have port B, input, N bits: unsigned multiplier, sampled only when start is accepted.
REQ-007 The block SHALL have port P, output, 2N bits: product register.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking P valid.

Function
REQ-010 Radix-2 shift-add unsigned multiply SHALL use internal registers M (N bits), ACC (N bits), Q (N bits), CNT (log2(N)+1 bits) and state.
REQ-011 The state machine SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE with start=1 at an edge -> load M=A, Q=B, ACC=0, CNT=0; go to RUN.
REQ-013 IDLE with start=0 -> all registers hold.
REQ-014 Each RUN edge: sum = ACC + (Q[0] ? M : 0), computed N+1 bits wide with carry c; then {ACC,Q} <= {c, sum[N-1:0], Q[N-1:1]}; CNT <= CNT+1.
REQ-015 The adder SHALL be a single N-bit adder with carry-in 0; its carry-out SHALL become ACC[N-1] after the shift, and no carry SHALL be lost.
REQ-016 RUN SHALL last exactly N edges; on the edge where CNT reaches N-1 before increment, next state SHALL be DONE.
REQ-017 DONE SHALL last one cycle; the next edge SHALL go to IDLE unconditionally.
REQ-018 done SHALL be a Moore output, 1 only in DONE.
REQ-019 Latency: start accepted at edge k -> done high in the cycle after edge k+N (edge k+16 for N=16) -> busy low after edge k+N+1.
REQ-020 P SHALL equal {ACC,Q} at all times.
REQ-021 P SHALL be guaranteed correct (A*B mod 2^(2N), exact) from the done cycle until the next accepted start.
REQ-022 P SHALL hold unchanged in IDLE.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing.
REQ-024 A and B changes after acceptance SHALL NOT affect the result.
REQ-025 Back-to-back operation: start held high continuously SHALL be accepted in the first IDLE cycle following DONE, giving one result per N+2 cycles.
REQ-026 Operand 0 or all-ones SHALL need no special-case logic.
REQ-027 Worst case 0xFFFF*0xFFFF SHALL yield 0xFFFE0001.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state=IDLE, ACC=0, Q=0, M=0, CNT=0, so P=0, busy=0, done=0.
REQ-029 rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-030 After rst deasserts, the first accepted start SHALL produce a correct result.

Verification
REQ-031 Basic: rst then A=3, B=5, start pulsed one cycle -> busy for 17 cycles; done one cycle after the 16th RUN edge; P=0x0000000F.
REQ-032 Max: A=0xFFFF, B=0xFFFF -> P=0xFFFE0001.
REQ-033 Zero and identity: A=0x1234, B=0 -> P=0; then A=1, B=0xBEEF -> P=0x0000BEEF.
REQ-034 Ignored start: A=2, B=7 accepted; at RUN cycle 5, start=1 with A=9, B=9 -> P=0x0000000E and exactly one done pulse.
REQ-035 Reset mid-op: A=0x00FF, B=0x0101 started; rst asserted at RUN cycle 8 -> P=0, busy=0 same cycle, no done; restart gives P=0x0000FFFF.
REQ-036 Back-to-back: start held high with A=0x8000, B=2 -> done every 18 cycles; P=0x00010000 each time.
